// File: rtl/lmem_fill_ctrl_if.sv
// Local-memory request channel: valid/ready handshake plus write/read request fields.
// The master drives the request; the slave returns ready.
interface lmem_fill_ctrl_if #(
    parameter int unsigned ADDR_WIDTH = 14,
    parameter int unsigned WORD_SIZE  = 4,
    parameter int unsigned TAG_WIDTH  = 16
);
    localparam int unsigned WORD_WIDTH = WORD_SIZE * 8;

    logic                  valid;
    logic                  rw;
    logic [ADDR_WIDTH-1:0] addr;
    logic [WORD_SIZE-1:0]  byteen;
    logic [WORD_WIDTH-1:0] data;
    logic [TAG_WIDTH-1:0]  tag;
    logic                  ready;

    modport master (
        output valid,
        output rw,
        output addr,
        output byteen,
        output data,
        output tag,
        input  ready
    );

    modport slave (
        input  valid,
        input  rw,
        input  addr,
        input  byteen,
        input  data,
        input  tag,
        output ready
    );
endinterface

// File: rtl/lmem_fill_ctrl.sv
// Fill/scrub sequencer for the local memory. Writes a captured fill value over a contiguous,
// wrapping word range while sharing the local-memory request port with one core port. A wait
// counter bounds how long a valid core request can be refused during a fill.
module lmem_fill_ctrl #(
    parameter int unsigned ADDR_WIDTH = 14,
    parameter int unsigned WORD_SIZE  = 4,
    parameter int unsigned TAG_WIDTH  = 16,
    parameter int unsigned MAX_WAIT   = 8
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     start,
    input  logic [ADDR_WIDTH-1:0]    start_addr,
    input  logic [ADDR_WIDTH:0]      start_count,
    input  logic [WORD_SIZE*8-1:0]   fill_data,
    output logic                     busy,
    output logic                     done,
    lmem_fill_ctrl_if.slave          core_req,
    lmem_fill_ctrl_if.master         mem_req
);

    localparam int unsigned WORD_WIDTH = WORD_SIZE * 8;
    localparam logic [7:0]  MaxWait    = 8'(MAX_WAIT);

    typedef enum logic [1:0] {StIdle, StFill, StDone} state_e;
    typedef enum logic {GrantCore, GrantFill} grant_e;

    state_e                state_q, state_d;
    grant_e                grant_q, grant_d;
    grant_e                grant;
    logic                  lock_q, lock_d;
    logic [7:0]            wait_q, wait_d;
    logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
    logic [ADDR_WIDTH:0]   cnt_q, cnt_d;
    logic [WORD_WIDTH-1:0] data_q, data_d;

    logic                  mem_valid;
    logic                  fill_hs;
    logic                  core_hs;

    // Effective grant this cycle; a stalled request keeps the grant it was presented under.
    always_comb begin
        grant = GrantFill;
        if (state_q != StFill) begin
            grant = GrantCore;
        end else if (lock_q) begin
            grant = grant_q;
        end else if (core_req.valid && (wait_q == MaxWait)) begin
            grant = GrantCore;
        end
    end

    // Request port mux: pass-through for the core, or the fill write.
    always_comb begin
        mem_valid       = core_req.valid;
        mem_req.rw      = core_req.rw;
        mem_req.addr    = core_req.addr;
        mem_req.byteen  = core_req.byteen;
        mem_req.data    = core_req.data;
        mem_req.tag     = core_req.tag;
        core_req.ready  = mem_req.ready;
        if (grant == GrantFill) begin
            mem_valid      = 1'b1;
            mem_req.rw     = 1'b1;
            mem_req.addr   = ptr_q;
            mem_req.byteen = '1;
            mem_req.data   = data_q;
            mem_req.tag    = '0;
            core_req.ready = 1'b0;
        end
    end

    assign mem_req.valid = mem_valid;
    assign fill_hs       = (grant == GrantFill) && mem_req.ready;
    assign core_hs       = (state_q == StFill) && (grant == GrantCore) && core_req.valid &&
                           mem_req.ready;
    assign busy          = (state_q != StIdle);
    assign done          = (state_q == StDone);

    // Sequencer next state: launch, walk the range, single-cycle completion.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    if (start_count != '0) begin
                        ptr_d   = start_addr;
                        cnt_d   = start_count;
                        data_d  = fill_data;
                        state_d = StFill;
                    end else begin
                        state_d = StDone;
                    end
                end
            end
            StFill: begin
                if (fill_hs) begin
                    ptr_d = ptr_q + ADDR_WIDTH'(1);
                    cnt_d = cnt_q - (ADDR_WIDTH + 1)'(1);
                    if (cnt_q == (ADDR_WIDTH + 1)'(1)) begin
                        state_d = StDone;
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Starvation counter and grant lock; the counter saturates so a long stall cannot overflow it.
    always_comb begin
        wait_d  = wait_q;
        lock_d  = 1'b0;
        grant_d = grant;
        if ((state_q != StFill) || core_hs) begin
            wait_d = '0;
        end else if (core_req.valid && (grant == GrantFill) && (wait_q != MaxWait)) begin
            wait_d = wait_q + 8'd1;
        end
        if ((state_q == StFill) && (state_d == StFill) && mem_valid && !mem_req.ready) begin
            lock_d = 1'b1;
        end
    end

    // State registers; reset aborts any fill in progress.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
            grant_q <= GrantCore;
            lock_q  <= 1'b0;
            wait_q  <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            lock_q  <= lock_d;
            wait_q  <= wait_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
        end
    end

endmodule

// File: tb/tb_lmem_fill_ctrl.sv
// Self-checking bench for lmem_fill_ctrl: randomized fills checked against a range/slot model.
module tb_lmem_fill_ctrl;
    localparam int AW = 14;
    localparam int WS = 4;
    localparam int TW = 16;
    localparam int WW = 32;
    localparam int MW = 3;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] start_addr = '0;
    logic [AW:0]   start_count = '0;
    logic [WW-1:0] fill_data = '0;
    logic          busy, done;

    lmem_fill_ctrl_if #(.ADDR_WIDTH(AW), .WORD_SIZE(WS), .TAG_WIDTH(TW)) core_if ();
    lmem_fill_ctrl_if #(.ADDR_WIDTH(AW), .WORD_SIZE(WS), .TAG_WIDTH(TW)) mem_if ();

    lmem_fill_ctrl #(
        .ADDR_WIDTH(AW), .WORD_SIZE(WS), .TAG_WIDTH(TW), .MAX_WAIT(MW)
    ) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .start_addr(start_addr),
        .start_count(start_count), .fill_data(fill_data), .busy(busy), .done(done),
        .core_req(core_if.slave), .mem_req(mem_if.master)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_fail = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int            cyc;
        bit            core;
        logic [AW-1:0] addr;
        logic [WW-1:0] data;
        logic [WS-1:0] be;
        logic [TW-1:0] tag;
        logic          rw;
    } obs_t;

    obs_t          obs[$];
    obs_t          o;
    int            done_cycs[$];
    int            busy_cnt = 0;
    bit            prev_stall = 0;
    logic [AW-1:0] prev_addr;
    logic [WW-1:0] prev_data;

    // Monitor: records accepted requests, done pulses, busy cycles; checks stall stability.
    always @(negedge clk) begin
        if (reset_n) begin
            if (mem_if.valid && mem_if.ready) begin
                o.cyc = cyc; o.core = core_if.valid && core_if.ready; o.addr = mem_if.addr;
                o.data = mem_if.data; o.be = mem_if.byteen; o.tag = mem_if.tag; o.rw = mem_if.rw;
                obs.push_back(o);
            end
            if (done) done_cycs.push_back(cyc);
            if (busy) busy_cnt++;
            if (prev_stall && busy) begin
                n_cmp++;
                if (mem_if.valid !== 1'b1 || mem_if.addr !== prev_addr || mem_if.data !== prev_data) begin
                    n_fail++;
                    $display("FAIL stall_stable: valid=%b addr=%h data=%h required valid=1 addr=%h data=%h",
                             mem_if.valid, mem_if.addr, mem_if.data, prev_addr, prev_data);
                end
            end
            prev_stall = busy && mem_if.valid && !mem_if.ready;
            prev_addr  = mem_if.addr;
            prev_data  = mem_if.data;
        end else begin
            prev_stall = 0;
        end
    end

    function automatic logic [AW-1:0] exp_addr(input logic [AW-1:0] a, input int i);
        return AW'(int'(a) + i);
    endfunction

    task automatic core_idle();
        core_if.valid = 0; core_if.rw = 0; core_if.addr = '0;
        core_if.byteen = '0; core_if.data = '0; core_if.tag = '0;
    endtask

    task automatic clear_obs();
        obs.delete(); done_cycs.delete(); busy_cnt = 0;
    endtask

    // Pulse start for one edge; e is the monitor cycle index of the cycle following that edge.
    task automatic do_start(input logic [AW-1:0] a, input logic [AW:0] n, input logic [WW-1:0] d,
                            output int e);
        @(posedge clk); #1;
        start = 1; start_addr = a; start_count = n; fill_data = d;
        @(posedge clk); #1;
        start = 0; e = cyc;
        start_addr = AW'($urandom); start_count = (AW + 1)'($urandom); fill_data = $urandom;
    endtask

    task automatic wait_done(input int budget, input string name);
        bit ok = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk); #1;
            if (done_cycs.size() > 0) begin ok = 1; break; end
        end
        if (!ok) begin
            n_cmp++; n_fail++;
            $display("FAIL %s_timeout: no done within %0d cycles, required done", name, budget);
        end
    endtask

    task automatic test_reset();
        logic [AW-1:0] a = AW'($urandom);
        logic [WW-1:0] d = $urandom;
        reset_n = 0; mem_if.ready = 0;
        core_if.valid = 1; core_if.rw = 1; core_if.addr = a; core_if.byteen = 4'h5;
        core_if.data = d; core_if.tag = 16'h1234;
        #12;
        n_cmp++; if (busy !== 0 || done !== 0) begin n_fail++;
            $display("FAIL reset_flags: busy=%b done=%b required 0 0", busy, done); end
        n_cmp++; if (mem_if.valid !== 1 || mem_if.addr !== a || mem_if.data !== d ||
                     mem_if.byteen !== 4'h5 || mem_if.tag !== 16'h1234 || mem_if.rw !== 1) begin n_fail++;
            $display("FAIL reset_passthru: valid=%b addr=%h data=%h required 1 %h %h",
                     mem_if.valid, mem_if.addr, mem_if.data, a, d); end
        n_cmp++; if (core_if.ready !== 0) begin n_fail++;
            $display("FAIL reset_ready0: ready=%b required 0", core_if.ready); end
        mem_if.ready = 1; #1;
        n_cmp++; if (core_if.ready !== 1) begin n_fail++;
            $display("FAIL reset_ready1: ready=%b required 1", core_if.ready); end
        core_if.valid = 0; #1;
        n_cmp++; if (mem_if.valid !== 0) begin n_fail++;
            $display("FAIL reset_valid0: valid=%b required 0", mem_if.valid); end
        core_idle();
        @(posedge clk); #1; reset_n = 1;
        repeat (2) @(posedge clk);
    endtask

    task automatic test_basic_fill();
        int e;
        clear_obs(); mem_if.ready = 1;
        do_start(14'h10, 15'd4, 32'h0, e);
        wait_done(20, "basic");
        repeat (3) @(negedge clk); #1;
        n_cmp++; if (obs.size() != 4) begin n_fail++;
            $display("FAIL basic_count: writes=%0d required 4", obs.size()); end
        for (int i = 0; i < obs.size() && i < 4; i++) begin
            n_cmp++;
            if (obs[i].addr !== exp_addr(14'h10, i) || obs[i].data !== 32'h0 || obs[i].be !== 4'hF ||
                obs[i].tag !== '0 || obs[i].rw !== 1 || obs[i].cyc != e + i || obs[i].core) begin
                n_fail++;
                $display("FAIL basic_wr%0d: addr=%h data=%h be=%h cyc=%0d required addr=%h data=0 be=F cyc=%0d",
                         i, obs[i].addr, obs[i].data, obs[i].be, obs[i].cyc, exp_addr(14'h10, i), e + i);
            end
        end
        n_cmp++; if (done_cycs.size() != 1 || done_cycs[0] != e + 4) begin n_fail++;
            $display("FAIL basic_done: pulses=%0d at=%0d required 1 at %0d", done_cycs.size(),
                     (done_cycs.size() > 0) ? done_cycs[0] : -1, e + 4); end
        n_cmp++; if (busy_cnt != 5) begin n_fail++;
            $display("FAIL basic_busy: cycles=%0d required 5", busy_cnt); end
    endtask

    task automatic test_zero_and_wrap();
        int e;
        logic [WW-1:0] d = $urandom;
        clear_obs();
        do_start(AW'($urandom), 15'd0, d, e);
        repeat (3) @(negedge clk); #1;
        n_cmp++; if (obs.size() != 0) begin n_fail++;
            $display("FAIL zero_writes: writes=%0d required 0", obs.size()); end
        n_cmp++; if (done_cycs.size() != 1 || done_cycs[0] != e) begin n_fail++;
            $display("FAIL zero_done: pulses=%0d at=%0d required 1 at %0d", done_cycs.size(),
                     (done_cycs.size() > 0) ? done_cycs[0] : -1, e); end
        clear_obs();
        do_start(14'h3FFE, 15'd3, d, e);
        wait_done(20, "wrap");
        n_cmp++; if (obs.size() != 3) begin n_fail++;
            $display("FAIL wrap_count: writes=%0d required 3", obs.size()); end
        for (int i = 0; i < obs.size() && i < 3; i++) begin
            n_cmp++;
            if (obs[i].addr !== exp_addr(14'h3FFE, i) || obs[i].data !== d) begin n_fail++;
                $display("FAIL wrap_wr%0d: addr=%h data=%h required addr=%h data=%h", i,
                         obs[i].addr, obs[i].data, exp_addr(14'h3FFE, i), d); end
        end
        repeat (2) @(posedge clk);
    endtask

    task automatic test_starvation();
        int e, w, fills, nfill, ncore, exp_ncore;
        bit exp_core[$];
        logic [AW-1:0] a = AW'($urandom);
        logic [AW-1:0] ca = AW'($urandom);
        logic [TW-1:0] ct = TW'($urandom);
        logic [WW-1:0] d = $urandom;
        // Slot model: a refused core request waits MW fill slots, then takes one slot.
        w = 0; fills = 0; exp_ncore = 0;
        while (fills < 10) begin
            if (w == MW) begin exp_core.push_back(1); w = 0; exp_ncore++; end
            else begin exp_core.push_back(0); fills++; w++; end
        end
        clear_obs(); mem_if.ready = 1;
        do_start(a, 15'd10, d, e);
        core_if.valid = 1; core_if.rw = 0; core_if.addr = ca; core_if.tag = ct;
        core_if.byteen = 4'hF; core_if.data = '0;
        wait_done(60, "starve");
        core_idle();
        nfill = 0; ncore = 0;
        for (int i = 0; i < obs.size() && obs[i].cyc < e + exp_core.size(); i++) begin
            n_cmp++;
            if (i >= exp_core.size() || obs[i].cyc != e + i || obs[i].core != exp_core[i] ||
                (obs[i].core && (obs[i].addr !== ca || obs[i].tag !== ct || obs[i].rw !== 0)) ||
                (!obs[i].core && (obs[i].addr !== exp_addr(a, nfill) || obs[i].data !== d))) begin
                n_fail++;
                $display("FAIL starve_slot%0d: core=%b addr=%h cyc=%0d required core=%b cyc=%0d",
                         i, obs[i].core, obs[i].addr, obs[i].cyc,
                         (i < exp_core.size()) ? exp_core[i] : 1'b0, e + i);
            end
            if (obs[i].core) ncore++; else nfill++;
        end
        n_cmp++; if (nfill != 10 || ncore != exp_ncore) begin n_fail++;
            $display("FAIL starve_totals: fills=%0d core=%0d required 10 %0d", nfill, ncore, exp_ncore); end
        n_cmp++; if (done_cycs.size() < 1 || done_cycs[0] != e + exp_core.size()) begin n_fail++;
            $display("FAIL starve_done: at=%0d required %0d",
                     (done_cycs.size() > 0) ? done_cycs[0] : -1, e + exp_core.size()); end
        repeat (2) @(posedge clk);
    endtask

    task automatic test_backpressure();
        int e;
        bit ok = 0;
        logic [AW-1:0] a = AW'($urandom);
        logic [WW-1:0] d = $urandom;
        clear_obs(); core_idle();
        do_start(a, 15'd6, d, e);
        for (int i = 0; i < 200; i++) begin
            mem_if.ready = (i == 0) ? 1'b0 : 1'($urandom % 2);
            @(posedge clk); #1;
            if (done_cycs.size() > 0) begin ok = 1; break; end
        end
        mem_if.ready = 1;
        if (!ok) begin n_cmp++; n_fail++;
            $display("FAIL bp_timeout: no done within 200 cycles, required done"); end
        n_cmp++; if (obs.size() != 6) begin n_fail++;
            $display("FAIL bp_count: writes=%0d required 6", obs.size()); end
        for (int i = 0; i < obs.size() && i < 6; i++) begin
            n_cmp++;
            if (obs[i].addr !== exp_addr(a, i) || obs[i].data !== d || obs[i].rw !== 1) begin n_fail++;
                $display("FAIL bp_wr%0d: addr=%h data=%h required addr=%h data=%h", i,
                         obs[i].addr, obs[i].data, exp_addr(a, i), d); end
        end
        repeat (2) @(posedge clk);
    endtask

    task automatic test_passthrough_ignore();
        int e;
        logic [WW-1:0] cd = $urandom;
        logic [WS-1:0] cb = WS'($urandom);
        logic [TW-1:0] ct = TW'($urandom);
        logic [AW-1:0] a = AW'($urandom);
        logic [WW-1:0] d = $urandom;
        mem_if.ready = 1;
        @(posedge clk); #1;
        core_if.valid = 1; core_if.rw = 1; core_if.addr = 14'h22; core_if.data = cd;
        core_if.byteen = cb; core_if.tag = ct;
        @(negedge clk);
        n_cmp++;
        if (mem_if.valid !== 1 || mem_if.rw !== 1 || mem_if.addr !== 14'h22 || mem_if.data !== cd ||
            mem_if.byteen !== cb || mem_if.tag !== ct || core_if.ready !== 1) begin n_fail++;
            $display("FAIL pass_fields: valid=%b addr=%h data=%h be=%h tag=%h rdy=%b required 1 22 %h %h %h 1",
                     mem_if.valid, mem_if.addr, mem_if.data, mem_if.byteen, mem_if.tag, core_if.ready,
                     cd, cb, ct); end
        mem_if.ready = 0; #1;
        n_cmp++; if (core_if.ready !== 0) begin n_fail++;
            $display("FAIL pass_ready: ready=%b required 0", core_if.ready); end
        mem_if.ready = 1;
        @(posedge clk); #1; core_idle();
        clear_obs();
        do_start(a, 15'd5, d, e);
        @(posedge clk); #1;
        start = 1; start_addr = a + 14'h100; start_count = 15'd2; fill_data = ~d;
        @(posedge clk); #1; start = 0;
        wait_done(30, "ignore");
        repeat (3) @(negedge clk); #1;
        n_cmp++; if (obs.size() != 5 || done_cycs.size() != 1 || done_cycs[0] != e + 5) begin n_fail++;
            $display("FAIL ignore_totals: writes=%0d pulses=%0d required 5 1 at %0d",
                     obs.size(), done_cycs.size(), e + 5); end
        for (int i = 0; i < obs.size() && i < 5; i++) begin
            n_cmp++;
            if (obs[i].addr !== exp_addr(a, i) || obs[i].data !== d) begin n_fail++;
                $display("FAIL ignore_wr%0d: addr=%h data=%h required addr=%h data=%h", i,
                         obs[i].addr, obs[i].data, exp_addr(a, i), d); end
        end
    endtask

    task automatic test_reset_mid();
        int e;
        logic [AW-1:0] a = AW'($urandom);
        logic [WW-1:0] d = $urandom;
        clear_obs(); mem_if.ready = 1; core_idle();
        do_start(a, 15'd8, d, e);
        @(posedge clk); @(posedge clk); #1;
        reset_n = 0; #1;
        n_cmp++; if (busy !== 0 || done !== 0 || mem_if.valid !== 0) begin n_fail++;
            $display("FAIL rmid_state: busy=%b done=%b valid=%b required 0 0 0", busy, done, mem_if.valid); end
        core_if.valid = 1; #1;
        n_cmp++; if (mem_if.valid !== 1) begin n_fail++;
            $display("FAIL rmid_follow: valid=%b required 1", mem_if.valid); end
        core_if.valid = 0;
        repeat (3) @(negedge clk);
        @(posedge clk); #1; reset_n = 1;
        repeat (3) @(negedge clk); #1;
        n_cmp++; if (obs.size() != 2 || done_cycs.size() != 0 || busy_cnt != 2) begin n_fail++;
            $display("FAIL rmid_abort: writes=%0d pulses=%0d busy=%0d required 2 0 2",
                     obs.size(), done_cycs.size(), busy_cnt); end
        clear_obs();
        a = AW'($urandom); d = $urandom;
        do_start(a, 15'd3, d, e);
        wait_done(20, "rmid_restart");
        n_cmp++; if (obs.size() != 3 || done_cycs.size() < 1 || done_cycs[0] != e + 3) begin n_fail++;
            $display("FAIL rmid_restart: writes=%0d done_at=%0d required 3 at %0d", obs.size(),
                     (done_cycs.size() > 0) ? done_cycs[0] : -1, e + 3); end
        for (int i = 0; i < obs.size() && i < 3; i++) begin
            n_cmp++;
            if (obs[i].addr !== exp_addr(a, i) || obs[i].data !== d) begin n_fail++;
                $display("FAIL rmid_wr%0d: addr=%h data=%h required addr=%h data=%h", i,
                         obs[i].addr, obs[i].data, exp_addr(a, i), d); end
        end
    endtask

    initial begin
        core_idle();
        mem_if.ready = 0;
        test_reset();
        test_basic_fill();
        test_zero_and_wrap();
        test_starvation();
        test_backpressure();
        test_passthrough_ignore();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/lmem_fill_ctrl.md
# lmem_fill_ctrl

Fill/scrub sequencer for the local memory. It writes a programmed fill value across a contiguous word range of the shared-memory address space, for example to zero it at kernel launch. It sits between one core request port and the corresponding local-memory request port, sharing that port between the core and the fill engine, with a starvation guard for the core. Write responses are dropped by the local memory, so this block handles requests only.

## Interface
- `ADDR_WIDTH`, 14: word-address width of the local memory (bank select plus bank address).
- `WORD_SIZE`, 4: bytes per word; `WORD_WIDTH = WORD_SIZE*8`.
- `TAG_WIDTH`, 16: request tag width.
- `MAX_WAIT`, 8: maximum number of consecutive cycles a valid core request may be refused during a fill. Legal range 1..255.
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  fill launch; sampled only in IDLE.
- `start_addr`  in  ADDR_WIDTH  first word address.
- `start_count`  in  ADDR_WIDTH+1  number of words to write; 0 is legal.
- `fill_data`  in  WORD_WIDTH  value to write; captured at start.
- `busy`  out  1  high whenever state != IDLE.
- `done`  out  1  one-cycle completion pulse.
- `core_req_valid`, `core_req_rw`, `core_req_addr[ADDR_WIDTH]`, `core_req_byteen[WORD_SIZE]`, `core_req_data[WORD_WIDTH]`, `core_req_tag[TAG_WIDTH]`  in  core request.
- `core_req_ready`  out  1  core request accepted.
- `mem_req_valid`, `mem_req_rw`, `mem_req_addr`, `mem_req_byteen`, `mem_req_data`, `mem_req_tag`  out  same widths  request to local memory.
- `mem_req_ready`  in  1  local memory accepts.

## Operation
- **States:** IDLE, FILL, DONE.
- **IDLE:**
  - `start` with `start_count != 0`: capture addr, count and data; go to FILL.
  - `start` with `start_count == 0`: go to DONE.
- **FILL:** go to DONE on the fill handshake that carries the last remaining word.
- **DONE:** `done = 1` for exactly one cycle, then back to IDLE.
- `start` is ignored while `busy`.
- **Fill request fields:**
  - rw=1, byteen all ones, data = captured `fill_data`, tag = 0, addr = current pointer.
  - On each fill handshake the pointer increments modulo 2^ADDR_WIDTH, so it wraps from max to 0, and the remaining count decrements.
- **Arbitration (grant register: CORE or FILL):**
  - In IDLE and DONE the core always holds the grant. The port is a pure pass-through: `mem_req_* = core_req_*`, `core_req_ready = mem_req_ready`.
  - In FILL the grant defaults to FILL. It goes to CORE for one handshake when `core_req_valid` and `wait_cnt == MAX_WAIT`.
  - `wait_cnt` increments every FILL cycle in which `core_req_valid` is high and the core is not granted. It clears on any core handshake and in IDLE.
  - The grant is locked while `mem_req_valid && !mem_req_ready`: the presented request and its fields stay stable until accepted.
  - The ungranted requester sees ready=0.
- `mem_req_valid` never depends combinationally on `mem_req_ready`.

## Timing
- **Reset values (async on `reset_n` low):**
  - Outputs: busy=0, done=0, mem_req_valid = core_req_valid (pass-through), core_req_ready = mem_req_ready.
  - Internal: state=IDLE, wait_cnt=0, pointer=0, count=0, grant=CORE.
- **Reset mid-fill:** aborts immediately. There is no done pulse and the remaining writes are lost.
- **Latency:**
  - `start` at edge N puts the first fill request valid in cycle N+1.
  - Throughput is 1 write/cycle with `mem_req_ready` held high.
  - `done` is high in the cycle after the last fill handshake; busy falls one cycle later.
- **Zero count:** `start` at edge N gives done in cycle N+1 and no writes.
- **Starvation bound:** a valid core request is accepted within MAX_WAIT+1 cycles of FILL, provided `mem_req_ready` is high.
- **Backpressure:** while `mem_req_ready=0` the pointer, count and grant hold. `wait_cnt` still counts, but it saturates at MAX_WAIT.

## Test plan
- **Basic fill:** start_addr=0x10, count=4, fill_data=0, ready=1, core idle -> writes to 0x10, 0x11, 0x12, 0x13 in four consecutive cycles, byteen=0xF; done one cycle after the last write; busy high for 5 cycles.
- **Zero count and wrap:**
  - count=0 -> done in the next cycle, no mem_req_valid.
  - start_addr=0x3FFE, count=3 -> addresses 0x3FFE, 0x3FFF, 0x0000.
- **Starvation guard:** MAX_WAIT=3, count=10, core read valid throughout -> core granted exactly once every 4th slot; the fill still completes all 10 writes; done after 10 fill handshakes plus the core handshakes.
- **Backpressure:** toggle mem_req_ready 1/0 randomly during a count=6 fill -> addr and data stable while stalled; all 6 addresses written exactly once, in order.
- **Pass-through and ignore:**
  - In IDLE, core write to 0x22 with ready=1 -> appears on the mem port in the same cycle, with identical fields.
  - A second start during FILL is ignored.
- **Reset mid-fill:** reset_n low after 2 of 8 writes -> mem_req_valid follows core_req_valid immediately; busy=0; no done pulse; a new start afterwards runs normally.
